// File: rtl/id_ex_if.sv
// id_ex_if: decode/register-file to execute handshake and payload bundle.
interface id_ex_if #(parameter int CTRL_W = 8, parameter int CNT_W = 16);
    logic              flush;
    logic              id_valid;
    logic              id_ready;
    logic [15:0]       id_pc;
    logic [3:0]        id_src1;
    logic [3:0]        id_src2;
    logic              id_use1;
    logic              id_use2;
    logic [3:0]        id_dst;
    logic              id_regwrite;
    logic              id_memread;
    logic [CTRL_W-1:0] id_ctrl;
    logic [15:0]       rf_data1;
    logic [15:0]       rf_data2;
    logic              ex_ready;
    logic              ex_valid;
    logic [15:0]       ex_pc;
    logic [15:0]       ex_a;
    logic [15:0]       ex_b;
    logic [3:0]        ex_dst;
    logic              ex_regwrite;
    logic              ex_memread;
    logic [CTRL_W-1:0] ex_ctrl;
    logic              hazard;
    logic [CNT_W-1:0]  stall_cnt;
    modport master (
        output flush, id_valid, id_pc, id_src1, id_src2, id_use1, id_use2, id_dst,
               id_regwrite, id_memread, id_ctrl, rf_data1, rf_data2, ex_ready,
        input  id_ready, ex_valid, ex_pc, ex_a, ex_b, ex_dst, ex_regwrite, ex_memread,
               ex_ctrl, hazard, stall_cnt
    );
    modport slave (
        input  flush, id_valid, id_pc, id_src1, id_src2, id_use1, id_use2, id_dst,
               id_regwrite, id_memread, id_ctrl, rf_data1, rf_data2, ex_ready,
        output id_ready, ex_valid, ex_pc, ex_a, ex_b, ex_dst, ex_regwrite, ex_memread,
               ex_ctrl, hazard, stall_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register with load-use bubble and stall counter.
module id_ex_stage #(
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input logic    clk,
    input logic    rst,
    id_ex_if.slave bus
);
    logic              v_q;
    logic [15:0]       pc_q;
    logic [15:0]       a_q;
    logic [15:0]       b_q;
    logic [3:0]        dst_q;
    logic              rw_q;
    logic              mr_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              src_hit;
    logic              hazard;
    logic              ready;
    logic              xfer;
    always_comb begin
        src_hit = (bus.id_use1 && bus.id_src1 == dst_q) || (bus.id_use2 && bus.id_src2 == dst_q);
        hazard  = bus.id_valid & v_q & mr_q & rw_q & src_hit;
        ready   = ~rst & ~bus.flush & ~hazard & (~v_q | bus.ex_ready);
        xfer    = bus.id_valid & ready;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q    <= 1'b0;
            pc_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            dst_q  <= '0;
            rw_q   <= 1'b0;
            mr_q   <= 1'b0;
            ctrl_q <= '0;
        end else if (bus.flush) begin
            v_q <= 1'b0;
        end else if (!(v_q && !bus.ex_ready)) begin
            v_q <= xfer;
            if (xfer) begin
                pc_q   <= bus.id_pc;
                a_q    <= bus.rf_data1;
                b_q    <= bus.rf_data2;
                dst_q  <= bus.id_dst;
                rw_q   <= bus.id_regwrite;
                mr_q   <= bus.id_memread;
                ctrl_q <= bus.id_ctrl;
            end
        end
    end
    // Counts stalled cycles only; a flushed cycle is not a stall.
    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else if (hazard && !bus.flush && cnt_q != '1)
            cnt_q <= cnt_q + 1'b1;
    end
    assign bus.id_ready    = ready;
    assign bus.hazard      = hazard;
    assign bus.ex_valid    = v_q;
    assign bus.ex_pc       = pc_q;
    assign bus.ex_a        = a_q;
    assign bus.ex_b        = b_q;
    assign bus.ex_dst      = dst_q;
    assign bus.ex_regwrite = rw_q;
    assign bus.ex_memread  = mr_q;
    assign bus.ex_ctrl     = ctrl_q;
    assign bus.stall_cnt   = cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of transfer, backpressure, load-use bubble, flush and counter saturation.
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total = 0;

    id_ex_if #(.CTRL_W(8), .CNT_W(4)) bus ();
    id_ex_stage #(.CTRL_W(8), .CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [15:0] pc, input logic [3:0] s1, input logic [3:0] s2,
                          input logic u1, input logic u2, input logic [3:0] dst, input logic rw,
                          input logic mr, input logic [7:0] ctrl, input logic [15:0] d1,
                          input logic [15:0] d2);
        bus.id_valid = 1'b1; bus.id_pc = pc; bus.id_src1 = s1; bus.id_src2 = s2;
        bus.id_use1 = u1; bus.id_use2 = u2; bus.id_dst = dst; bus.id_regwrite = rw;
        bus.id_memread = mr; bus.id_ctrl = ctrl; bus.rf_data1 = d1; bus.rf_data2 = d2;
    endtask

    task automatic test_reset;
        bus.flush = 1'b0; bus.ex_ready = 1'b1;
        set_id(16'h0999, 4'd1, 4'd2, 1'b1, 1'b1, 4'd9, 1'b1, 1'b1, 8'hFF, 16'hFFFF, 16'hFFFF);
        rst = 1'b1;
        cyc(); cyc();
        total++; if (bus.ex_valid !== 1'b0) $display("FAIL reset_ex_valid got %h want 0", bus.ex_valid); else passed++;
        total++; if (bus.id_ready !== 1'b0) $display("FAIL reset_id_ready got %h want 0", bus.id_ready); else passed++;
        total++; if (bus.stall_cnt !== 4'd0) $display("FAIL reset_stall_cnt got %0d want 0", bus.stall_cnt); else passed++;
        total++; if (bus.ex_pc !== 16'h0 || bus.ex_a !== 16'h0 || bus.ex_ctrl !== 8'h0) $display("FAIL reset_payload got pc=%h a=%h ctrl=%h want 0", bus.ex_pc, bus.ex_a, bus.ex_ctrl); else passed++;
        rst = 1'b0; bus.id_valid = 1'b0;
        #1;
        total++; if (bus.id_ready !== 1'b1) $display("FAIL post_reset_id_ready got %h want 1", bus.id_ready); else passed++;
    endtask

    task automatic test_pass_through;
        set_id(16'h0010, 4'd1, 4'd2, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 8'hA5, 16'h1234, 16'hABCD);
        #1;
        total++; if (bus.id_ready !== 1'b1) $display("FAIL pass_id_ready got %h want 1", bus.id_ready); else passed++;
        cyc();
        total++; if (bus.ex_valid !== 1'b1) $display("FAIL pass_ex_valid got %h want 1", bus.ex_valid); else passed++;
        total++; if (bus.ex_a !== 16'h1234 || bus.ex_b !== 16'hABCD) $display("FAIL pass_operands got a=%h b=%h want 1234 abcd", bus.ex_a, bus.ex_b); else passed++;
        total++; if (bus.ex_pc !== 16'h0010 || bus.ex_dst !== 4'd5 || bus.ex_ctrl !== 8'hA5 || bus.ex_regwrite !== 1'b1 || bus.ex_memread !== 1'b0)
            $display("FAIL pass_fields got pc=%h dst=%h ctrl=%h rw=%h mr=%h want 0010 5 a5 1 0", bus.ex_pc, bus.ex_dst, bus.ex_ctrl, bus.ex_regwrite, bus.ex_memread); else passed++;
    endtask

    task automatic test_back_to_back;
        set_id(16'h0014, 4'd3, 4'd4, 1'b1, 1'b1, 4'd6, 1'b1, 1'b0, 8'h11, 16'h1111, 16'h2222);
        #1;
        total++; if (bus.id_ready !== 1'b1) $display("FAIL b2b_id_ready got %h want 1", bus.id_ready); else passed++;
        cyc();
        total++; if (bus.ex_pc !== 16'h0014 || bus.ex_a !== 16'h1111 || bus.ex_valid !== 1'b1) $display("FAIL b2b_first got pc=%h a=%h v=%h want 0014 1111 1", bus.ex_pc, bus.ex_a, bus.ex_valid); else passed++;
        set_id(16'h0018, 4'd5, 4'd6, 1'b1, 1'b1, 4'd7, 1'b1, 1'b0, 8'h22, 16'h3333, 16'h4444);
        cyc();
        total++; if (bus.ex_pc !== 16'h0018 || bus.ex_b !== 16'h4444) $display("FAIL b2b_second got pc=%h b=%h want 0018 4444", bus.ex_pc, bus.ex_b); else passed++;
        bus.id_valid = 1'b0;
        cyc();
        total++; if (bus.ex_valid !== 1'b0 || bus.ex_pc !== 16'h0018) $display("FAIL b2b_drain got v=%h pc=%h want 0 0018", bus.ex_valid, bus.ex_pc); else passed++;
    endtask

    task automatic test_backpressure;
        set_id(16'h0020, 4'd1, 4'd2, 1'b1, 1'b1, 4'd8, 1'b1, 1'b0, 8'h33, 16'h0A0A, 16'h0C0C);
        cyc();
        bus.ex_ready = 1'b0;
        set_id(16'h0024, 4'd1, 4'd2, 1'b1, 1'b1, 4'd9, 1'b1, 1'b0, 8'h44, 16'h0B0B, 16'h0D0D);
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (bus.id_ready !== 1'b0) $display("FAIL bp_id_ready cycle %0d got %h want 0", i, bus.id_ready); else passed++;
            cyc();
            total++; if (bus.ex_valid !== 1'b1 || bus.ex_pc !== 16'h0020 || bus.ex_a !== 16'h0A0A || bus.ex_ctrl !== 8'h33)
                $display("FAIL bp_hold cycle %0d got v=%h pc=%h a=%h ctrl=%h want 1 0020 0a0a 33", i, bus.ex_valid, bus.ex_pc, bus.ex_a, bus.ex_ctrl); else passed++;
        end
        bus.ex_ready = 1'b1;
        #1;
        total++; if (bus.id_ready !== 1'b1) $display("FAIL bp_release_ready got %h want 1", bus.id_ready); else passed++;
        cyc();
        total++; if (bus.ex_pc !== 16'h0024 || bus.ex_a !== 16'h0B0B || bus.ex_valid !== 1'b1) $display("FAIL bp_release_load got pc=%h a=%h v=%h want 0024 0b0b 1", bus.ex_pc, bus.ex_a, bus.ex_valid); else passed++;
    endtask

    task automatic test_load_use;
        set_id(16'h0030, 4'd0, 4'd0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b1, 8'h55, 16'h0100, 16'h0200);
        cyc();
        set_id(16'h0034, 4'd0, 4'd3, 1'b0, 1'b1, 4'd4, 1'b1, 1'b0, 8'h66, 16'h5555, 16'h6666);
        #1;
        total++; if (bus.hazard !== 1'b1 || bus.id_ready !== 1'b0) $display("FAIL lu_detect got hazard=%h ready=%h want 1 0", bus.hazard, bus.id_ready); else passed++;
        cyc();
        total++; if (bus.ex_valid !== 1'b0 || bus.stall_cnt !== 4'd1) $display("FAIL lu_bubble got v=%h cnt=%0d want 0 1", bus.ex_valid, bus.stall_cnt); else passed++;
        total++; if (bus.hazard !== 1'b0 || bus.id_ready !== 1'b1) $display("FAIL lu_clear got hazard=%h ready=%h want 0 1", bus.hazard, bus.id_ready); else passed++;
        cyc();
        total++; if (bus.ex_valid !== 1'b1 || bus.ex_pc !== 16'h0034 || bus.ex_b !== 16'h6666 || bus.stall_cnt !== 4'd1)
            $display("FAIL lu_dependent got v=%h pc=%h b=%h cnt=%0d want 1 0034 6666 1", bus.ex_valid, bus.ex_pc, bus.ex_b, bus.stall_cnt); else passed++;
        set_id(16'h0040, 4'd0, 4'd0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b1, 8'h77, 16'h0300, 16'h0400);
        cyc();
        set_id(16'h0044, 4'd0, 4'd3, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0, 8'h88, 16'h7777, 16'h8888);
        #1;
        total++; if (bus.hazard !== 1'b0 || bus.id_ready !== 1'b1) $display("FAIL lu_unused_src got hazard=%h ready=%h want 0 1", bus.hazard, bus.id_ready); else passed++;
        cyc();
        total++; if (bus.ex_pc !== 16'h0044 || bus.ex_valid !== 1'b1 || bus.stall_cnt !== 4'd1) $display("FAIL lu_unused_load got pc=%h v=%h cnt=%0d want 0044 1 1", bus.ex_pc, bus.ex_valid, bus.stall_cnt); else passed++;
    endtask

    task automatic test_flush;
        bus.ex_ready = 1'b0;
        set_id(16'h0050, 4'd1, 4'd2, 1'b1, 1'b1, 4'd6, 1'b1, 1'b0, 8'h99, 16'h9999, 16'hAAAA);
        bus.flush = 1'b1;
        #1;
        total++; if (bus.id_ready !== 1'b0) $display("FAIL flush_id_ready got %h want 0", bus.id_ready); else passed++;
        cyc();
        total++; if (bus.ex_valid !== 1'b0 || bus.stall_cnt !== 4'd1) $display("FAIL flush_drop got v=%h cnt=%0d want 0 1", bus.ex_valid, bus.stall_cnt); else passed++;
        bus.flush = 1'b0; bus.ex_ready = 1'b1;
        set_id(16'h0060, 4'd0, 4'd0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b1, 8'hBB, 16'h0500, 16'h0600);
        cyc();
        set_id(16'h0064, 4'd3, 4'd0, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0, 8'hCC, 16'hCCCC, 16'hDDDD);
        bus.ex_ready = 1'b0; bus.flush = 1'b1;
        #1;
        total++; if (bus.hazard !== 1'b1 || bus.id_ready !== 1'b0) $display("FAIL flush_hazard got hazard=%h ready=%h want 1 0", bus.hazard, bus.id_ready); else passed++;
        cyc();
        total++; if (bus.ex_valid !== 1'b0 || bus.stall_cnt !== 4'd1) $display("FAIL flush_no_count got v=%h cnt=%0d want 0 1", bus.ex_valid, bus.stall_cnt); else passed++;
        bus.flush = 1'b0;
    endtask

    task automatic test_saturation;
        bus.ex_ready = 1'b1;
        set_id(16'h0070, 4'd0, 4'd0, 1'b0, 1'b0, 4'd7, 1'b1, 1'b1, 8'hDE, 16'h0700, 16'h0800);
        cyc();
        bus.ex_ready = 1'b0;
        set_id(16'h0074, 4'd7, 4'd0, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0, 8'hEF, 16'hEEEE, 16'hFFFF);
        for (int i = 1; i <= 20; i++) begin
            cyc();
            if (i == 5) begin
                total++; if (bus.stall_cnt !== 4'd6) $display("FAIL sat_mid got %0d want 6", bus.stall_cnt); else passed++;
            end
            if (i == 14) begin
                total++; if (bus.stall_cnt !== 4'd15) $display("FAIL sat_reach got %0d want 15", bus.stall_cnt); else passed++;
            end
        end
        total++; if (bus.stall_cnt !== 4'd15) $display("FAIL sat_hold got %0d want 15", bus.stall_cnt); else passed++;
        total++; if (bus.ex_valid !== 1'b1 || bus.ex_pc !== 16'h0070) $display("FAIL sat_load_held got v=%h pc=%h want 1 0070", bus.ex_valid, bus.ex_pc); else passed++;
    endtask

    initial begin
        bus.flush = 1'b0; bus.id_valid = 1'b0; bus.ex_ready = 1'b1;
        test_reset();
        test_pass_through();
        test_back_to_back();
        test_backpressure();
        test_load_use();
        test_flush();
        test_saturation();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
